hdsiso8_sequencer: RTL and testbench

HDSISO8_SEQUENCER -- requirements
Module: hdsiso8_sequencer

---
 rtl/hdsiso8_sequencer.sv | 87 ++++++++
 tb/tb_hdsiso8_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdsiso8_sequencer.sv
// Eight-phase Gray sequencer driving a SISO shift datapath, with an optional PRBS source.
// Optional LFSR and din_sel selection are built only when HDSISO8_SEQ_LFSR_EN is defined.
module hdsiso8_sequencer #(
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       d_in,
  input  logic       din_sel,
  input  logic       lfsr_en,
  output logic [2:0] gray,
  output logic [7:0] pulse,
  output logic       shift_strobe,
  output logic       sr_din,
  output logic       lfsr_bit,
  output logic       lfsr_period
);

  logic [2:0] idx;
  logic [2:0] idx_nxt;
  logic       wrap;
  logic       sel_bit;

  assign idx_nxt = idx + 3'd1;
  assign wrap    = run_en && (idx == 3'd7);

  // Binary index to reflected Gray; 7 -> 0 differs in one bit (100 -> 000).
  function automatic logic [2:0] gray_of(input logic [2:0] i);
    return i ^ (i >> 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= 3'd0;
      gray         <= 3'd0;
      pulse        <= 8'd0;
      shift_strobe <= 1'b0;
      sr_din       <= 1'b0;
    end else begin
      shift_strobe <= wrap;
      if (run_en) begin
        idx   <= idx_nxt;
        gray  <= gray_of(idx_nxt);
        pulse <= 8'd1 << idx_nxt;
      end else begin
        pulse <= 8'd0;
      end
      if (wrap) sr_din <= sel_bit;
    end
  end

`ifdef HDSISO8_SEQ_LFSR_EN
  logic [7:0] s;
  logic [7:0] s_step;
  logic       fb;

  assign fb       = s[7] ^ s[5] ^ s[4] ^ s[3];
  assign s_step   = {s[6:0], fb};
  assign sel_bit  = din_sel ? s[7] : d_in;
  assign lfsr_bit = s[7];

  // All-zero lock-up is escaped on the very next clock, whatever lfsr_en says.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s           <= LFSR_SEED;
      lfsr_period <= 1'b0;
    end else if (s == 8'h00) begin
      s           <= LFSR_SEED;
      lfsr_period <= 1'b0;
    end else if (wrap && lfsr_en) begin
      s           <= s_step;
      lfsr_period <= (s_step == LFSR_SEED);
    end else begin
      lfsr_period <= 1'b0;
    end
  end
`else
  logic unused_lfsr_inputs;

  assign unused_lfsr_inputs = din_sel ^ lfsr_en;
  assign sel_bit            = d_in;
  assign lfsr_bit           = 1'b0;
  assign lfsr_period        = 1'b0;
`endif

endmodule

// File: tb/tb_hdsiso8_sequencer.sv
// Directed bench for hdsiso8_sequencer: phase walk, holds, wraps, async reset, data source.
module tb_hdsiso8_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run_en;
  logic       d_in;
  logic       din_sel;
  logic       lfsr_en;
  logic [2:0] gray;
  logic [7:0] pulse;
  logic       shift_strobe;
  logic       sr_din;
  logic       lfsr_bit;
  logic       lfsr_period;

  int total = 0;
  int bad   = 0;

  hdsiso8_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
    .d_in         (d_in),
    .din_sel      (din_sel),
    .lfsr_en      (lfsr_en),
    .gray         (gray),
    .pulse        (pulse),
    .shift_strobe (shift_strobe),
    .sr_din       (sr_din),
    .lfsr_bit     (lfsr_bit),
    .lfsr_period  (lfsr_period)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run_en  = 1'b0;
    d_in    = 1'b0;
    din_sel = 1'b0;
    lfsr_en = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (gray !== 3'b000) begin bad++; $display("FAIL reset_gray got=%b want=000", gray); end
    total++; if (pulse !== 8'h00) begin bad++; $display("FAIL reset_pulse got=%h want=00", pulse); end
    total++; if (shift_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", shift_strobe); end
    total++; if (sr_din !== 1'b0) begin bad++; $display("FAIL reset_sr_din got=%b want=0", sr_din); end
    total++; if (lfsr_bit !== 1'b0) begin bad++; $display("FAIL reset_lfsr_bit got=%b want=0", lfsr_bit); end
    total++; if (lfsr_period !== 1'b0) begin bad++; $display("FAIL reset_lfsr_period got=%b want=0", lfsr_period); end
  endtask

  task automatic test_run9();
    logic [2:0] exp_g [9];
    logic [7:0] exp_p [9];
    exp_g = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    exp_p = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    do_reset();
    run_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++; if (gray !== exp_g[i]) begin bad++; $display("FAIL run9_gray[%0d] got=%b want=%b", i, gray, exp_g[i]); end
      total++; if (pulse !== exp_p[i]) begin bad++; $display("FAIL run9_pulse[%0d] got=%h want=%h", i, pulse, exp_p[i]); end
      total++; if (shift_strobe !== (i == 7)) begin bad++; $display("FAIL run9_strobe[%0d] got=%b want=%b", i, shift_strobe, (i == 7)); end
    end
    run_en = 1'b0;
  endtask

  task automatic test_toggle();
    logic       en_v  [3];
    logic [2:0] exp_g [3];
    logic [7:0] exp_p [3];
    en_v  = '{1'b1, 1'b0, 1'b1};
    exp_g = '{3'b001, 3'b001, 3'b011};
    exp_p = '{8'h02, 8'h00, 8'h04};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_en = en_v[i];
      tick();
      total++; if (gray !== exp_g[i]) begin bad++; $display("FAIL toggle_gray[%0d] got=%b want=%b", i, gray, exp_g[i]); end
      total++; if (pulse !== exp_p[i]) begin bad++; $display("FAIL toggle_pulse[%0d] got=%h want=%h", i, pulse, exp_p[i]); end
    end
    run_en = 1'b0;
  endtask

  // d_in is captured only at wrap edges and held in between.
  task automatic test_sr_din_capture();
    do_reset();
    d_in    = 1'b1;
    din_sel = 1'b1;
    run_en  = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    total++; if (sr_din !== 1'b0) begin bad++; $display("FAIL capture_pre_wrap got=%b want=0", sr_din); end
`ifndef HDSISO8_SEQ_LFSR_EN
    tick();
    total++; if (sr_din !== 1'b1) begin bad++; $display("FAIL capture_first_wrap got=%b want=1", sr_din); end
    d_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++; if (sr_din !== 1'b1) begin bad++; $display("FAIL capture_hold[%0d] got=%b want=1", i, sr_din); end
      total++; if (lfsr_bit !== 1'b0 || lfsr_period !== 1'b0) begin
        bad++; $display("FAIL capture_lfsr_idle got=%b%b want=00", lfsr_bit, lfsr_period);
      end
    end
    tick();
    total++; if (sr_din !== 1'b0) begin bad++; $display("FAIL capture_second_wrap got=%b want=0", sr_din); end
`else
    din_sel = 1'b0;
    tick();
    total++; if (sr_din !== 1'b1) begin bad++; $display("FAIL capture_first_wrap got=%b want=1", sr_din); end
`endif
    run_en = 1'b0;
  endtask

  // Pause exactly at index 7; the resumed edge must be the wrap.
  task automatic test_pause_at_7();
    do_reset();
    run_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    run_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (gray !== 3'b100) begin bad++; $display("FAIL pause_gray[%0d] got=%b want=100", i, gray); end
      total++; if (pulse !== 8'h00) begin bad++; $display("FAIL pause_pulse[%0d] got=%h want=00", i, pulse); end
    end
    d_in   = 1'b1;
    run_en = 1'b1;
    tick();
    total++; if (gray !== 3'b000) begin bad++; $display("FAIL resume_gray got=%b want=000", gray); end
    total++; if (pulse !== 8'h01) begin bad++; $display("FAIL resume_pulse got=%h want=01", pulse); end
    total++; if (shift_strobe !== 1'b1) begin bad++; $display("FAIL resume_strobe got=%b want=1", shift_strobe); end
    total++; if (sr_din !== 1'b1) begin bad++; $display("FAIL resume_sr_din got=%b want=1", sr_din); end
    tick();
    total++; if (shift_strobe !== 1'b0) begin bad++; $display("FAIL resume_strobe_drop got=%b want=0", shift_strobe); end
    run_en = 1'b0;
  endtask

  // Async reset mid-sequence, then the first edge after release is functional.
  task automatic test_async_reset();
    do_reset();
    d_in   = 1'b1;
    lfsr_en = 1'b1;
    run_en = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    total++; if (gray !== 3'b111 || sr_din !== 1'b1) begin
      bad++; $display("FAIL areset_setup gray=%b sr_din=%b want=111/1", gray, sr_din);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gray !== 3'b000) begin bad++; $display("FAIL areset_gray got=%b want=000", gray); end
    total++; if (pulse !== 8'h00) begin bad++; $display("FAIL areset_pulse got=%h want=00", pulse); end
    total++; if (shift_strobe !== 1'b0) begin bad++; $display("FAIL areset_strobe got=%b want=0", shift_strobe); end
    total++; if (sr_din !== 1'b0) begin bad++; $display("FAIL areset_sr_din got=%b want=0", sr_din); end
    total++; if (lfsr_period !== 1'b0) begin bad++; $display("FAIL areset_period got=%b want=0", lfsr_period); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (gray !== 3'b001) begin bad++; $display("FAIL post_reset_gray got=%b want=001", gray); end
    total++; if (pulse !== 8'h02) begin bad++; $display("FAIL post_reset_pulse got=%h want=02", pulse); end
    run_en  = 1'b0;
    lfsr_en = 1'b0;
  endtask

`ifdef HDSISO8_SEQ_LFSR_EN
  function automatic logic [7:0] lfsr_model(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic test_lfsr_walk();
    logic [7:0] m;
    logic       prev_msb;
    do_reset();
    m = 8'h01;
    lfsr_en = 1'b1;
    din_sel = 1'b1;
    run_en  = 1'b1;
    for (int w = 0; w < 12; w++) begin
      prev_msb = m[7];
      m = lfsr_model(m);
      for (int i = 0; i < 8; i++) tick();
      total++; if (lfsr_bit !== m[7]) begin bad++; $display("FAIL lfsr_bit[%0d] got=%b want=%b", w, lfsr_bit, m[7]); end
      total++; if (sr_din !== prev_msb) begin bad++; $display("FAIL lfsr_sr_din[%0d] got=%b want=%b", w, sr_din, prev_msb); end
    end
    run_en = 1'b0;
  endtask

  task automatic test_lfsr_period();
    int pulses;
    int at_wrap;
    do_reset();
    pulses  = 0;
    at_wrap = 0;
    lfsr_en = 1'b1;
    run_en  = 1'b1;
    for (int k = 1; k <= 255 * 8; k++) begin
      tick();
      if (lfsr_period === 1'b1) begin
        pulses++;
        at_wrap = k / 8;
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL period_count got=%0d want=1", pulses); end
    total++; if (at_wrap != 255) begin bad++; $display("FAIL period_wrap got=%0d want=255", at_wrap); end
    run_en = 1'b0;
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    run_en  = 1'b0;
    d_in    = 1'b0;
    din_sel = 1'b0;
    lfsr_en = 1'b0;
    test_reset();
    test_run9();
    test_toggle();
    test_sr_din_capture();
    test_pause_at_7();
    test_async_reset();
`ifdef HDSISO8_SEQ_LFSR_EN
    test_lfsr_walk();
    test_lfsr_period();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
